// File: rtl/ninjin_dispatch.sv
// ninjin_dispatch: launch sequencer for the NCORE accelerator tops.
// Runs the core req/ack handshake with start timeout and owns the image-memory mux.
module ninjin_dispatch #(
  parameter int NCORE    = 2,
  parameter int SELW     = 3,
  parameter int IMGSIZE  = 12,
  parameter int DWIDTH   = 16,
  parameter int CNTW     = 32,
  parameter int START_TO = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SELW-1:0]          sel,
  input  logic                     req_in,
  input  logic                     abort,
  input  logic                     irq_clr,
  output logic [NCORE-1:0]         core_req,
  input  logic [NCORE-1:0]         core_ack,
  input  logic [NCORE-1:0]         core_mem_we,
  input  logic [NCORE*IMGSIZE-1:0] core_mem_addr,
  input  logic [NCORE*DWIDTH-1:0]  core_mem_wdata,
  input  logic                     host_we,
  input  logic [IMGSIZE-1:0]       host_addr,
  input  logic [DWIDTH-1:0]        host_wdata,
  output logic                     mem_we,
  output logic [IMGSIZE-1:0]       mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  output logic [SELW-1:0]          active_sel,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err,
  output logic                     irq,
  output logic [CNTW-1:0]          cycles
);

  localparam int TOW = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(START_TO - 1);
  localparam logic [SELW:0] NCORE_W = (SELW+1)'(NCORE);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEL  = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;
  localparam logic [1:0] ERR_HOST = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [NCORE-1:0]  core_req_q, core_req_d;
  logic [SELW-1:0]   asel_q, asel_d;
  logic [1:0]        err_q, err_d;
  logic              done_q, done_d;
  logic              irq_q;
  logic              irq_set;
  logic [CNTW-1:0]   cyc_q, cyc_d;
  logic [TOW-1:0]    to_q, to_d;
  logic              req_in_q;

  logic              launch;
  logic              sel_ok;
  logic              run_ph;
  logic              req_on;
  logic [NCORE-1:0]  onehot;
  logic              ack_sel;
  logic              c_we;
  logic [IMGSIZE-1:0] c_addr;
  logic [DWIDTH-1:0] c_wdata;

  assign launch = req_in & ~req_in_q;
  assign sel_ok = ({1'b0, sel} < NCORE_W);
  assign run_ph = (state_q == S_START) || (state_q == S_RUN);
  assign req_on = |core_req_q;

  // Only the latched core is ever looked at; other slices are don't-care.
  always_comb begin
    onehot  = '0;
    ack_sel = 1'b0;
    c_we    = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    for (int k = 0; k < NCORE; k++) begin
      if (asel_q == SELW'(k)) begin
        onehot[k] = 1'b1;
        ack_sel   = core_ack[k];
        c_we      = core_mem_we[k];
        c_addr    = core_mem_addr[k*IMGSIZE +: IMGSIZE];
        c_wdata   = core_mem_wdata[k*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    core_req_d = core_req_q;
    asel_d     = asel_q;
    err_d      = err_q;
    done_d     = done_q;
    irq_set    = 1'b0;
    cyc_d      = cyc_q;
    to_d       = to_q;

    if (run_ph && !(&cyc_q)) begin
      cyc_d = cyc_q + CNTW'(1);
    end

    if (abort) begin
      state_d    = S_IDLE;
      core_req_d = '0;
    end else begin
      if (run_ph && host_we) begin
        err_d = ERR_HOST;
      end
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            done_d = 1'b0;
            if (sel_ok) begin
              state_d = S_START;
              asel_d  = sel;
              cyc_d   = '0;
              to_d    = '0;
              err_d   = ERR_NONE;
            end else begin
              state_d = S_ERR;
              err_d   = ERR_SEL;
              irq_set = 1'b1;
            end
          end
        end
        S_START: begin
          // req goes out one cycle after entry; ack only counts once it is out
          if (!req_on) begin
            core_req_d = onehot;
          end else if (!ack_sel) begin
            state_d = S_RUN;
          end else if (to_q == TO_LAST) begin
            state_d    = S_ERR;
            err_d      = ERR_TO;
            irq_set    = 1'b1;
            core_req_d = '0;
          end else begin
            to_d = to_q + TOW'(1);
          end
        end
        S_RUN: begin
          if (ack_sel) begin
            state_d    = S_DONE;
            core_req_d = '0;
            done_d     = 1'b1;
            irq_set    = 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (!req_in) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          core_req_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      core_req_q <= '0;
      asel_q     <= '0;
      err_q      <= ERR_NONE;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      cyc_q      <= '0;
      to_q       <= '0;
      req_in_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_req_q <= core_req_d;
      asel_q     <= asel_d;
      err_q      <= err_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      to_q       <= to_d;
      req_in_q   <= req_in;
      if (irq_set) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign mem_we    = run_ph ? c_we    : host_we;
  assign mem_addr  = run_ph ? c_addr  : host_addr;
  assign mem_wdata = run_ph ? c_wdata : host_wdata;

  assign core_req   = core_req_q;
  assign active_sel = asel_q;
  assign busy       = run_ph;
  assign done       = done_q;
  assign err        = err_q;
  assign irq        = irq_q;
  assign cycles     = cyc_q;

endmodule
